log2_x: RTL and testbench



---
 rtl/log2_x_pkg.sv | 16 +
 rtl/log2_x_if.sv | 16 +
 rtl/log2_x_lzd.sv | 17 +
 rtl/log2_x.sv | 112 +++++++++++
 tb/tb_log2_x.sv | 125 ++++++++++++
 5 files changed

// File: rtl/log2_x_pkg.sv
// Shared constants and types for the log2_x fixed-point logarithm unit.
// The optional LOG2X_DONE_EN macro is handled in log2_x_if.sv and log2_x.sv.
package log2_x_pkg;
  localparam int IW  = 5;
  localparam int FWI = 3;
  localparam int FWO = 5;
  localparam int MW  = 16;
  localparam int OW  = 6 + FWO;
  localparam int AW  = IW + FWI;
  localparam int PW  = $clog2(AW);
  localparam int CW  = $clog2(FWO + 1);

  typedef enum logic [1:0] {LOAD, NORM, ITER, DONE} state_e;

  localparam logic [OW-1:0] LOG2_ZERO_SAT = 11'b100000_00000;
endpackage

// File: rtl/log2_x_if.sv
// Operand/result bundle for log2_x; `done` exists only when LOG2X_DONE_EN is defined.
interface log2_x_if;
  import log2_x_pkg::*;

  logic [IW-1:-FWI] a;
  logic [OW-1:0]    o;
`ifdef LOG2X_DONE_EN
  logic             done;

  modport master (output a, input o, input done);
  modport slave  (input a, output o, output done);
`else
  modport master (output a, input o);
  modport slave  (input a, output o);
`endif
endinterface

// File: rtl/log2_x_lzd.sv
// Combinational leading-one detector: bit position of the MSB set and an all-zero flag.
module log2_x_lzd
  import log2_x_pkg::*;
(
  input  logic [AW-1:0] a_i,
  output logic [PW-1:0] pos_o,
  output logic          zero_o
);
  always_comb begin
    pos_o  = '0;
    zero_o = (a_i == '0);
    // Ascending scan so the highest set bit wins.
    for (int b = 0; b < AW; b++) begin
      if (a_i[b]) pos_o = PW'(b);
    end
  end
endmodule

// File: rtl/log2_x.sv
// Free-running sequential log2: Q5.3 unsigned in, Q6.5 signed out, 8 cycles per result.
// Define LOG2X_DONE_EN to add a one-cycle `done` strobe registered alongside `o`.
module log2_x
  import log2_x_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  log2_x_if.slave  bus
);
  state_e             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic signed [5:0]  k_q, k_d;
  logic               zero_q, zero_d;
  logic [MW:0]        y_q, y_d;
  logic [FWO-1:0]     frac_q, frac_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OW-1:0]      o_q, o_d;
  logic               done_q, done_d;

  logic [PW-1:0]      lzd_pos;
  logic               lzd_zero;
  logic [2*MW+1:0]    sq;
  logic               sq_ge2;
  logic [MW:0]        y_norm;

  function automatic logic [OW-1:0] sat_result(input logic zero,
                                               input logic signed [5:0] k,
                                               input logic [FWO-1:0] frac);
    return zero ? LOG2_ZERO_SAT : {k, frac};
  endfunction

  log2_x_lzd u_lzd (
    .a_i    (a_q),
    .pos_o  (lzd_pos),
    .zero_o (lzd_zero)
  );

  // Full-precision square of 1.MW mantissa, truncated back to 2.MW then renormalised.
  assign sq     = (2*MW+2)'(y_q) * (2*MW+2)'(y_q);
  assign sq_ge2 = sq[2*MW+1];
  assign y_norm = {a_q, {(MW+1-AW){1'b0}}} << (PW'(AW-1) - lzd_pos);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    k_d     = k_q;
    zero_d  = zero_q;
    y_d     = y_q;
    frac_d  = frac_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    done_d  = 1'b0;
    case (state_q)
      LOAD: begin
        a_d     = bus.a;
        state_d = NORM;
      end
      NORM: begin
        k_d     = $signed({{(6-PW){1'b0}}, lzd_pos}) - 6'sd3;
        zero_d  = lzd_zero;
        y_d     = y_norm;
        frac_d  = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        frac_d = {frac_q[FWO-2:0], sq_ge2};
        y_d    = sq_ge2 ? sq[2*MW+1:MW+1] : sq[2*MW:MW];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(FWO-1)) state_d = DONE;
      end
      DONE: begin
        o_d     = sat_result(zero_q, k_q, frac_q);
        done_d  = 1'b1;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      a_q     <= '0;
      k_q     <= '0;
      zero_q  <= 1'b0;
      y_q     <= '0;
      frac_q  <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      k_q     <= k_d;
      zero_q  <= zero_d;
      y_q     <= y_d;
      frac_q  <= frac_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      done_q  <= done_d;
    end
  end

  assign bus.o = o_q;
`ifdef LOG2X_DONE_EN
  assign bus.done = done_q;
`else
  logic unused_done;
  assign unused_done = done_q;
`endif
endmodule

// File: tb/tb_log2_x.sv
// Directed and random bench for log2_x against an arithmetic log2 reference model.
module tb_log2_x;
  import log2_x_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [OW-1:0] prev_o;

  always #5 clk = ~clk;

  log2_x_if bus_if ();

  log2_x dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Reference: k = floor(log2(a)), then the squaring recurrence on an integer mantissa.
  function automatic logic [OW-1:0] model(input logic [7:0] av);
    longint y, y2, v;
    int e, k, frac;
    if (av == 0) return 11'b100000_00000;
    v = longint'(av);
    e = 0;
    while ((longint'(1) << (e + 1)) <= v) e++;
    k = e - 3;
    y = v << (MW - e);
    frac = 0;
    for (int i = 1; i <= FWO; i++) begin
      y2 = (y * y) >> MW;
      if (y2 >= (longint'(2) << MW)) begin
        frac = frac + (1 << (FWO - i));
        y = y2 >> 1;
      end else begin
        y = y2;
      end
    end
    return {6'(k), 5'(frac)};
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_done(input string tag, input logic exp);
`ifdef LOG2X_DONE_EN
    check(tag, {10'b0, bus_if.done}, {10'b0, exp});
`else
    if (exp === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  // Called at a negedge just before a LOAD edge; consumes exactly 8 rising edges.
  task automatic run_conv(input string tag, input logic [7:0] av, input logic [OW-1:0] exp,
                          input bit mid, input logic [7:0] mid_av);
    bus_if.a = av;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      if (mid && i == 2) begin
        #1 bus_if.a = mid_av;
      end
    end
    #1;
    check({tag, "_held"}, bus_if.o, prev_o);
    check_done({tag, "_done_lo"}, 1'b0);
    @(posedge clk);
    #1;
    check(tag, bus_if.o, exp);
    check_done({tag, "_done_hi"}, 1'b1);
    prev_o = exp;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] r;
    bus_if.a = 8'b01111_000;
    prev_o = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_o", bus_if.o, 11'b0);
    check_done("reset_done", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_conv("a_15_0",   8'b01111_000, 11'b000011_11101, 1'b0, 8'h00);
    run_conv("a_1_0",    8'b00001_000, 11'b000000_00000, 1'b0, 8'h00);
    run_conv("a_0_125",  8'b00000_001, 11'b111101_00000, 1'b0, 8'h00);
    run_conv("a_2_5",    8'b00010_100, 11'b000001_01010, 1'b0, 8'h00);
    run_conv("a_max",    8'hFF,        11'b000100_11111, 1'b0, 8'h00);
    run_conv("a_zero",   8'h00,        11'b100000_00000, 1'b0, 8'h00);
    run_conv("a_pow2_16", 8'b10000_000, 11'b000100_00000, 1'b0, 8'h00);
    run_conv("mid_first", 8'h28, model(8'h28), 1'b1, 8'h0C);
    run_conv("mid_next",  8'h0C, model(8'h0C), 1'b0, 8'h00);

    for (int n = 0; n < 24; n++) begin
      r = 8'($urandom_range(0, 255));
      run_conv($sformatf("rand_%0d_a%02h", n, r), r, model(r), 1'b0, 8'h00);
    end

    // Abort a conversion while it is iterating.
    bus_if.a = 8'h37;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_o", bus_if.o, 11'b0);
    check_done("rst_mid_done", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    prev_o = '0;
    run_conv("after_rst", 8'h37, model(8'h37), 1'b0, 8'h00);
    run_conv("after_rst2", 8'h03, model(8'h03), 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
